bip_control: RTL

Sequencing controller for the accumulator datapath (`TOP_datapath`). It owns the program counter and fetches instructions from a synchronous program ROM. It decodes the 5-bit opcode and drives the datapath mux selects, accumulator write, add/sub select and data-RAM strobes, running a two-cycle FETCH/EXEC loop until a HLT instruction is executed.

---
 rtl/bip_defs.sv | 43 ++++
 rtl/bip_decoder.sv | 53 +++++
 rtl/bip_control.sv | 76 +++++++
 3 files changed

// File: rtl/bip_defs.sv
// rtl/bip_defs.sv - shared opcodes, state encodings and datapath select codes for the BIP controller
package bip_defs;

    localparam int OPC_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_EXEC  = 2'b10,
        ST_HALT  = 2'b11
    } state_t;

    localparam logic [OPC_W-1:0] OPC_HLT  = 5'b00000;
    localparam logic [OPC_W-1:0] OPC_STO  = 5'b00001;
    localparam logic [OPC_W-1:0] OPC_LD   = 5'b00010;
    localparam logic [OPC_W-1:0] OPC_LDI  = 5'b00011;
    localparam logic [OPC_W-1:0] OPC_ADD  = 5'b00100;
    localparam logic [OPC_W-1:0] OPC_ADDI = 5'b00101;
    localparam logic [OPC_W-1:0] OPC_SUB  = 5'b00110;
    localparam logic [OPC_W-1:0] OPC_SUBI = 5'b00111;

    localparam logic [1:0] SEL_A_RAM = 2'd0;
    localparam logic [1:0] SEL_A_IMM = 2'd1;
    localparam logic [1:0] SEL_A_ALU = 2'd2;

    localparam logic SEL_B_RAM = 1'b0;
    localparam logic SEL_B_IMM = 1'b1;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic [1:0] sel_a;
        logic       sel_b;
        logic       wr_acc;
        logic       op;
        logic       wr_ram;
        logic       rd_ram;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/bip_decoder.sv
// rtl/bip_decoder.sv - combinational opcode to datapath control decode
module bip_decoder
    import bip_defs::*;
(
    input  logic [OPC_W-1:0] opcode,
    output ctrl_t            ctrl
);

    always_comb begin
        ctrl = CTRL_NONE;
        case (opcode)
            OPC_STO: ctrl.wr_ram = 1'b1;
            OPC_LD: begin
                ctrl.sel_a  = SEL_A_RAM;
                ctrl.wr_acc = 1'b1;
                ctrl.rd_ram = 1'b1;
            end
            OPC_LDI: begin
                ctrl.sel_a  = SEL_A_IMM;
                ctrl.wr_acc = 1'b1;
            end
            OPC_ADD: begin
                ctrl.sel_a  = SEL_A_ALU;
                ctrl.sel_b  = SEL_B_RAM;
                ctrl.op     = OP_ADD;
                ctrl.wr_acc = 1'b1;
                ctrl.rd_ram = 1'b1;
            end
            OPC_ADDI: begin
                ctrl.sel_a  = SEL_A_ALU;
                ctrl.sel_b  = SEL_B_IMM;
                ctrl.op     = OP_ADD;
                ctrl.wr_acc = 1'b1;
            end
            OPC_SUB: begin
                ctrl.sel_a  = SEL_A_ALU;
                ctrl.sel_b  = SEL_B_RAM;
                ctrl.op     = OP_SUB;
                ctrl.wr_acc = 1'b1;
                ctrl.rd_ram = 1'b1;
            end
            OPC_SUBI: begin
                ctrl.sel_a  = SEL_A_ALU;
                ctrl.sel_b  = SEL_B_IMM;
                ctrl.op     = OP_SUB;
                ctrl.wr_acc = 1'b1;
            end
            // HLT and unknown opcodes leave every control low
            default: ;
        endcase
    end

endmodule

// File: rtl/bip_control.sv
// rtl/bip_control.sv - FETCH/EXEC sequencer: program counter, decode gating and halt
module bip_control
    import bip_defs::*;
#(
    parameter int N_BUS    = 16,
    parameter int N_BUS_IN = 11,
    parameter int TAM      = 2,
    parameter int N_CNT    = 16
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_enable,
    input  logic [N_BUS-1:0]    i_instruction,
    output logic [N_BUS_IN-1:0] o_pc,
    output logic [N_BUS_IN-1:0] o_operand,
    output logic [TAM-1:0]      o_selA,
    output logic                o_selB,
    output logic                o_WrAcc,
    output logic                o_OP,
    output logic                o_WrRam,
    output logic                o_RdRam,
    output logic                o_halt,
    output logic [N_CNT-1:0]    o_instr_count
);

    state_t           state;
    ctrl_t            dec;
    logic [OPC_W-1:0] opcode;
    logic             in_exec;

    assign opcode  = i_instruction[N_BUS-1 -: OPC_W];
    assign in_exec = (state == ST_EXEC);

    bip_decoder u_decoder (
        .opcode (opcode),
        .ctrl   (dec)
    );

    // Controls are forced low outside EXEC so no stray RAM or accumulator write can occur
    assign o_selA    = in_exec ? TAM'(dec.sel_a) : '0;
    assign o_selB    = in_exec & dec.sel_b;
    assign o_WrAcc   = in_exec & dec.wr_acc;
    assign o_OP      = in_exec & dec.op;
    assign o_WrRam   = in_exec & dec.wr_ram;
    assign o_RdRam   = in_exec & dec.rd_ram;
    assign o_operand = in_exec ? i_instruction[N_BUS_IN-1:0] : '0;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state         <= ST_IDLE;
            o_pc          <= '0;
            o_instr_count <= '0;
            o_halt        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_enable) state <= ST_FETCH;
                end
                ST_FETCH: state <= ST_EXEC;
                ST_EXEC: begin
                    o_instr_count <= o_instr_count + N_CNT'(1);
                    if (opcode == OPC_HLT) begin
                        state  <= ST_HALT;
                        o_halt <= 1'b1;
                    end else begin
                        o_pc  <= o_pc + N_BUS_IN'(1);
                        state <= i_enable ? ST_FETCH : ST_IDLE;
                    end
                end
                ST_HALT: state <= ST_HALT;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
